// File: rtl/mcu_pkg.sv
// Shared types and constants for the MCU instruction-cycle sequencer.
// Includes the Moore decode from sequencer state to datapath control strobes.
package mcu_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        INTR  = 2'b11
    } state_t;

    localparam logic [1:0] PC_MUX_FROM_IR = 2'b00;
    localparam logic [1:0] PC_MUX_VECTOR  = 2'b10;
    localparam logic [1:0] SCR_ADDR_SP_M1 = 2'b11;

    typedef struct packed {
        logic       mcu_rst;
        logic       ir_ld;
        logic       pc_inc;
        logic       exec_en;
        logic       int_pc_ld;
        logic [1:0] pc_mux_sel;
        logic       sp_decr;
        logic       scr_we;
        logic [1:0] scr_addr_sel;
        logic       scr_data_sel;
        logic       flg_shad_ld;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = '0;
        c.pc_mux_sel = PC_MUX_FROM_IR;
        case (st)
            INIT:  c.mcu_rst = 1'b1;
            FETCH: begin
                c.ir_ld  = 1'b1;
                c.pc_inc = 1'b1;
            end
            EXEC:  c.exec_en = 1'b1;
            INTR: begin
                // Interrupt entry: push PC at SP-1, shadow flags, jump to vector
                c.int_pc_ld    = 1'b1;
                c.pc_mux_sel   = PC_MUX_VECTOR;
                c.sp_decr      = 1'b1;
                c.scr_we       = 1'b1;
                c.scr_addr_sel = SCR_ADDR_SP_M1;
                c.scr_data_sel = 1'b1;
                c.flg_shad_ld  = 1'b1;
            end
            default: c.mcu_rst = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcu_sequencer_if.sv
// Decoder/datapath control bundle of the sequencer.
// master = sequencer side, slave = decoder/datapath side.
interface mcu_sequencer_if;
    import mcu_pkg::*;

    logic       I_SET;
    logic       I_CLR;
    logic       MCU_RST;
    logic       IR_LD;
    logic       PC_INC;
    logic       EXEC_EN;
    logic       INT_PC_LD;
    logic [1:0] PC_MUX_SEL;
    logic       SP_DECR;
    logic       SCR_WE;
    logic [1:0] SCR_ADDR_SEL;
    logic       SCR_DATA_SEL;
    logic       FLG_SHAD_LD;
    logic       I_FLAG;
    logic       INT_PEND;
    logic [1:0] STATE;
    logic [9:0] INT_VECTOR;

    modport master (
        input  I_SET, I_CLR,
        output MCU_RST, IR_LD, PC_INC, EXEC_EN, INT_PC_LD, PC_MUX_SEL,
               SP_DECR, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, FLG_SHAD_LD,
               I_FLAG, INT_PEND, STATE, INT_VECTOR
    );

    modport slave (
        output I_SET, I_CLR,
        input  MCU_RST, IR_LD, PC_INC, EXEC_EN, INT_PC_LD, PC_MUX_SEL,
               SP_DECR, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, FLG_SHAD_LD,
               I_FLAG, INT_PEND, STATE, INT_VECTOR
    );

endinterface

// File: rtl/int_sync.sv
// Multi-flop synchronizer for the asynchronous INT line followed by a
// rising-edge detector; INT_RISE is a single-cycle pulse.
module int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic INT,
    output logic INT_RISE
);

    // Fewer than two flops is not a safe synchronizer, so clamp the depth
    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] sync_q;
    logic         edge_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], INT};
            edge_q <= sync_q[N-1];
        end
    end

    assign INT_RISE = sync_q[N-1] & ~edge_q;

endmodule

// File: rtl/mcu_sequencer.sv
// INIT/FETCH/EXEC/INTR instruction-cycle sequencer with interrupt-enable flag,
// sticky pending-interrupt capture and registered Moore control outputs.
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter logic [9:0] VECTOR      = 10'h3FF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            INT,
    mcu_sequencer_if.master bus
);

    state_t state_q;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   i_flag_q;
    logic   int_pend_q;
    logic   int_rise;

    int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .INT      (INT),
        .INT_RISE (int_rise)
    );

    always_comb begin
        state_nxt = INIT;
        case (state_q)
            INIT:    state_nxt = FETCH;
            FETCH:   state_nxt = EXEC;
            // Decision uses the enable flag as registered before this EXEC
            EXEC:    state_nxt = (int_pend_q && i_flag_q) ? INTR : FETCH;
            INTR:    state_nxt = FETCH;
            default: state_nxt = INIT;
        endcase
    end

    // Outputs are decoded from the next state so they stay aligned with STATE
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= INIT;
            ctrl_q     <= decode_ctrl(INIT);
            i_flag_q   <= 1'b0;
            int_pend_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= decode_ctrl(state_nxt);

            if (state_q == INTR || state_nxt == INTR) begin
                i_flag_q <= 1'b0;
            end else if (state_q == EXEC) begin
                if (bus.I_CLR) begin
                    i_flag_q <= 1'b0;
                end else if (bus.I_SET) begin
                    i_flag_q <= 1'b1;
                end
            end

            // A fresh edge beats the clear on INTR exit
            if (int_rise) begin
                int_pend_q <= 1'b1;
            end else if (state_q == INTR) begin
                int_pend_q <= 1'b0;
            end
        end
    end

    assign bus.STATE        = state_q;
    assign bus.MCU_RST      = ctrl_q.mcu_rst;
    assign bus.IR_LD        = ctrl_q.ir_ld;
    assign bus.PC_INC       = ctrl_q.pc_inc;
    assign bus.EXEC_EN      = ctrl_q.exec_en;
    assign bus.INT_PC_LD    = ctrl_q.int_pc_ld;
    assign bus.PC_MUX_SEL   = ctrl_q.pc_mux_sel;
    assign bus.SP_DECR      = ctrl_q.sp_decr;
    assign bus.SCR_WE       = ctrl_q.scr_we;
    assign bus.SCR_ADDR_SEL = ctrl_q.scr_addr_sel;
    assign bus.SCR_DATA_SEL = ctrl_q.scr_data_sel;
    assign bus.FLG_SHAD_LD  = ctrl_q.flg_shad_ld;
    assign bus.I_FLAG       = i_flag_q;
    assign bus.INT_PEND     = int_pend_q;
    assign bus.INT_VECTOR   = VECTOR;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Bench for mcu_sequencer: directed scenarios plus randomized traffic, all
// compared against a cycle-level behavioural model of the sequencer rules.
module tb_mcu_sequencer;

    localparam int S = 2;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;
    logic INT     = 1'b0;

    mcu_sequencer_if bus();

    mcu_sequencer #(.VECTOR(10'h3FF), .SYNC_STAGES(S)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .INT     (INT),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0=INIT 1=FETCH 2=EXEC 3=INTR
    int m_state = 0;
    bit m_iflag = 1'b0;
    bit m_pend  = 1'b0;
    bit hist [0:S] = '{default: 1'b0};

    // {STATE, MCU_RST, IR_LD, PC_INC, EXEC_EN, INT_PC_LD, PC_MUX_SEL, SP_DECR,
    //  SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, FLG_SHAD_LD, I_FLAG, INT_PEND}
    wire [16:0] dut_vec = {bus.STATE, bus.MCU_RST, bus.IR_LD, bus.PC_INC,
                           bus.EXEC_EN, bus.INT_PC_LD, bus.PC_MUX_SEL,
                           bus.SP_DECR, bus.SCR_WE, bus.SCR_ADDR_SEL,
                           bus.SCR_DATA_SEL, bus.FLG_SHAD_LD, bus.I_FLAG,
                           bus.INT_PEND};

    localparam logic [16:0] RESET_VEC = 17'h04000;
    localparam logic [16:0] INTR_VEC  = 17'h186FD; // INTR, I_FLAG=0, INT_PEND=1

    function automatic logic [16:0] exp_vec(input int st, input bit iflag, input bit pend);
        logic [16:0] v;
        v = '0;
        v[16:15] = st[1:0];
        case (st)
            0: v[14] = 1'b1;
            1: begin v[13] = 1'b1; v[12] = 1'b1; end
            2: v[11] = 1'b1;
            default: begin
                v[10] = 1'b1; v[9:8] = 2'b10; v[7] = 1'b1; v[6] = 1'b1;
                v[5:4] = 2'b11; v[3] = 1'b1; v[2] = 1'b1;
            end
        endcase
        v[1] = iflag;
        v[0] = pend;
        return v;
    endfunction

    // Behavioural model: an edge is seen S edges after INT was sampled high
    always @(posedge CLK or negedge RESET_N) begin : model
        bit rise;
        int nst;
        bit nif;
        if (!RESET_N) begin
            m_state <= 0;
            m_iflag <= 1'b0;
            m_pend  <= 1'b0;
            for (int i = 0; i <= S; i++) hist[i] <= 1'b0;
        end else begin
            rise = hist[S-1] && !hist[S];
            if (m_state == 0)      nst = 1;
            else if (m_state == 1) nst = 2;
            else if (m_state == 2) nst = (m_pend && m_iflag) ? 3 : 1;
            else                   nst = 1;
            if (nst == 3 || m_state == 3) nif = 1'b0;
            else if (m_state == 2)        nif = bus.I_CLR ? 1'b0 : (bus.I_SET ? 1'b1 : m_iflag);
            else                          nif = m_iflag;
            m_state <= nst;
            m_iflag <= nif;
            m_pend  <= rise ? 1'b1 : ((m_state == 3) ? 1'b0 : m_pend);
            for (int i = S; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= INT;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
        RESET_N = 1'b0; INT = 1'b0; bus.I_SET = 1'b0; bus.I_CLR = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, RESET_VEC);
        end
        n_tests++;
        if (bus.INT_VECTOR !== 10'h3FF) begin
            n_fail++; $display("FAIL int_vector: got %h expected 3ff", bus.INT_VECTOR);
        end
        RESET_N = 1'b1;
        n_tests++;
        if (bus.STATE !== 2'b00 || bus.MCU_RST !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_init: state %b mcu_rst %b expected 00/1", bus.STATE, bus.MCU_RST);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.STATE !== seq[i] || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
                n_fail++;
                $display("FAIL reset_seq[%0d]: got %h expected state %b vec %h", i, dut_vec, seq[i],
                         exp_vec(m_state, m_iflag, m_pend));
            end
        end
    endtask

    task automatic test_int_disabled();
        INT = 1'b1;
        tick(); tick();
        n_tests++;
        if (bus.INT_PEND !== 1'b0 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL pend_latency_early: got pend %b expected 0", bus.INT_PEND);
        end
        tick();
        n_tests++;
        if (bus.INT_PEND !== 1'b1 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL pend_latency: got pend %b expected 1", bus.INT_PEND);
        end
        INT = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (bus.STATE === 2'b11 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
                n_fail++; $display("FAIL masked_hold[%0d]: got %h expected %h", i, dut_vec,
                                   exp_vec(m_state, m_iflag, m_pend));
            end
        end
        for (int i = 0; i < 4 && bus.STATE !== 2'b10; i++) tick();
        bus.I_SET = 1'b1;
        tick();
        bus.I_SET = 1'b0;
        n_tests++;
        if (bus.STATE !== 2'b01 || bus.I_FLAG !== 1'b1) begin
            n_fail++; $display("FAIL sei_no_immediate_intr: state %b iflag %b expected 01/1", bus.STATE, bus.I_FLAG);
        end
        tick();
        tick();
        n_tests++;
        if (dut_vec !== INTR_VEC) begin
            n_fail++; $display("FAIL masked_then_intr: got %h expected %h", dut_vec, INTR_VEC);
        end
        tick();
        n_tests++;
        if (bus.STATE !== 2'b01 || bus.I_FLAG !== 1'b0 || bus.INT_PEND !== 1'b0 || bus.SCR_WE !== 1'b0) begin
            n_fail++; $display("FAIL intr_exit: got %h expected state 01 iflag 0 pend 0", dut_vec);
        end
    endtask

    task automatic test_int_entry();
        int cyc;
        for (int i = 0; i < 4 && bus.STATE !== 2'b10; i++) tick();
        bus.I_SET = 1'b1;
        tick();
        bus.I_SET = 1'b0;
        INT = 1'b1;
        cyc = 0;
        while (bus.STATE !== 2'b11 && cyc < 10) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (bus.STATE !== 2'b11 || cyc > 6) begin
            n_fail++; $display("FAIL intr_latency: state %b after %0d cycles expected 11 within 6", bus.STATE, cyc);
        end
        n_tests++;
        if (dut_vec !== INTR_VEC) begin
            n_fail++; $display("FAIL intr_outputs: got %h expected %h", dut_vec, INTR_VEC);
        end
        tick();
        n_tests++;
        if (dut_vec !== exp_vec(1, 1'b0, 1'b0) || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL intr_one_cycle: got %h expected %h", dut_vec, exp_vec(1, 1'b0, 1'b0));
        end
        // INT still high: re-enabling must not produce another request
        for (int i = 0; i < 4 && bus.STATE !== 2'b10; i++) tick();
        bus.I_SET = 1'b1;
        tick();
        bus.I_SET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (bus.STATE === 2'b11 || bus.INT_PEND !== 1'b0 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
                n_fail++; $display("FAIL level_no_retrigger[%0d]: got %h expected %h", i, dut_vec,
                                   exp_vec(m_state, m_iflag, m_pend));
            end
        end
        INT = 1'b0;
    endtask

    task automatic test_priority();
        for (int i = 0; i < 4 && bus.STATE !== 2'b01; i++) tick();
        bus.I_CLR = 1'b1;
        tick();
        bus.I_CLR = 1'b0;
        n_tests++;
        if (bus.I_FLAG !== 1'b1 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL cli_in_fetch_ignored: got iflag %b expected 1", bus.I_FLAG);
        end
        bus.I_SET = 1'b1;
        bus.I_CLR = 1'b1;
        tick();
        bus.I_SET = 1'b0;
        bus.I_CLR = 1'b0;
        n_tests++;
        if (bus.I_FLAG !== 1'b0 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL clr_over_set: got iflag %b expected 0", bus.I_FLAG);
        end
        bus.I_SET = 1'b1;
        tick();
        bus.I_SET = 1'b0;
        n_tests++;
        if (bus.I_FLAG !== 1'b0 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL sei_in_fetch_ignored: got iflag %b expected 0", bus.I_FLAG);
        end
    endtask

    task automatic test_retrigger();
        INT = 1'b1;
        repeat (3) tick();
        INT = 1'b0;
        n_tests++;
        if (bus.INT_PEND !== 1'b1) begin
            n_fail++; $display("FAIL retrig_pend: got %b expected 1", bus.INT_PEND);
        end
        for (int i = 0; i < 4 && bus.STATE !== 2'b10; i++) tick();
        bus.I_SET = 1'b1;
        tick();
        bus.I_SET = 1'b0;
        INT = 1'b1;              // detected during the upcoming INTR cycle
        tick();
        tick();
        n_tests++;
        if (bus.STATE !== 2'b11 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL retrig_first_intr: got %h expected state 11", dut_vec);
        end
        tick();
        INT = 1'b0;
        n_tests++;
        if (bus.STATE !== 2'b01 || bus.INT_PEND !== 1'b1 || bus.I_FLAG !== 1'b0) begin
            n_fail++; $display("FAIL retrig_pend_kept: got %h expected state 01 pend 1 iflag 0", dut_vec);
        end
        tick();
        bus.I_SET = 1'b1;
        tick();
        bus.I_SET = 1'b0;
        n_tests++;
        if (bus.STATE !== 2'b01 || bus.I_FLAG !== 1'b1) begin
            n_fail++; $display("FAIL retie_no_immediate: got %h expected state 01 iflag 1", dut_vec);
        end
        tick();
        tick();
        n_tests++;
        if (bus.STATE !== 2'b11 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL retrig_second_intr: got %h expected state 11", dut_vec);
        end
        tick();
        n_tests++;
        if (bus.INT_PEND !== 1'b0 || bus.I_FLAG !== 1'b0 || bus.STATE !== 2'b01) begin
            n_fail++; $display("FAIL retrig_cleared: got %h expected state 01 pend 0 iflag 0", dut_vec);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) INT = ~INT;
            bus.I_SET = ($urandom_range(3) == 0);
            bus.I_CLR = ($urandom_range(4) == 0);
            tick();
            n_tests++;
            if (dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec,
                                   exp_vec(m_state, m_iflag, m_pend));
            end
        end
        bus.I_SET = 1'b0;
        bus.I_CLR = 1'b0;
        INT = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4 && bus.STATE !== 2'b10; i++) tick();
        bus.I_SET = 1'b1;
        tick();
        bus.I_SET = 1'b0;
        INT = 1'b1;
        for (int i = 0; i < 12 && bus.STATE !== 2'b11; i++) tick();
        INT = 1'b0;
        n_tests++;
        if (bus.STATE !== 2'b11) begin
            n_fail++; $display("FAIL arst_reach_intr: got state %b expected 11", bus.STATE);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== RESET_VEC || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL arst_in_intr: got %h expected %h", dut_vec, RESET_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.SCR_WE !== 1'b0 || dut_vec !== RESET_VEC) begin
                n_fail++; $display("FAIL arst_hold[%0d]: got %h expected %h", i, dut_vec, RESET_VEC);
            end
        end
        RESET_N = 1'b1;
        tick();
        n_tests++;
        if (bus.STATE !== 2'b01 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL arst_release: got %h expected state 01", dut_vec);
        end
        for (int i = 0; i < 4 && bus.STATE !== 2'b10; i++) tick();
        #2 RESET_N = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL arst_in_exec: got %h expected %h", dut_vec, RESET_VEC);
        end
        tick();
        RESET_N = 1'b1;
        tick();
        n_tests++;
        if (bus.STATE !== 2'b01 || dut_vec !== exp_vec(m_state, m_iflag, m_pend)) begin
            n_fail++; $display("FAIL arst_exec_release: got %h expected state 01", dut_vec);
        end
    endtask

    initial begin
        bus.I_SET = 1'b0;
        bus.I_CLR = 1'b0;
        test_reset();
        test_int_disabled();
        test_int_entry();
        test_priority();
        test_retrigger();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
Top-level instruction-cycle sequencer for the 18-bit-instruction MCU. It owns the INIT/FETCH/EXEC/INTR state machine, the interrupt-enable flag and interrupt-request capture. It gates the decoder's single-cycle control outputs into the execute phase only. It also drives the datapath controls for interrupt entry: push PC to scratch RAM, decrement SP, shadow flags, load vector.

Parameters:
VECTOR, 10'h3FF, interrupt vector address; the program counter mux selects it when PC_MUX_SEL = 2'b10.
SYNC_STAGES, 2, synchronizer depth on INT (minimum 2).

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
INT  in  1  asynchronous external interrupt request, rising-edge sensitive
I_SET  in  1  decoder: SEI/RETIE this instruction
I_CLR  in  1  decoder: CLI/RETID this instruction
MCU_RST  out  1  resets PC, SP, flags in datapath
IR_LD  out  1  load instruction register
PC_INC  out  1  increment program counter
EXEC_EN  out  1  qualifies all decoder outputs (RF_WR, PC_LD, IO_STRB, FLG_*)
INT_PC_LD  out  1  load PC from vector
PC_MUX_SEL  out  2  2'b10 during INTR, else 2'b00
SP_DECR  out  1  decrement stack pointer
SCR_WE  out  1  scratch RAM write
SCR_ADDR_SEL  out  2  2'b11 (SP-1) during INTR, else 2'b00
SCR_DATA_SEL  out  1  1 = PC as scratch data
FLG_SHAD_LD  out  1  copy C/Z into shadow flags
I_FLAG  out  1  interrupt enable state
INT_PEND  out  1  latched pending interrupt
STATE  out  2  INIT=00, FETCH=01, EXEC=10, INTR=11 (debug)

Behaviour:
- Reset (async, RESET_N low): STATE=INIT, I_FLAG=0, INT_PEND=0, synchronizer and edge registers=0. All outputs are 0 except MCU_RST=1.
- All outputs are Moore decodes of STATE, registered state only. No output depends combinationally on INT.
- INIT: MCU_RST=1. Unconditionally goes to FETCH on the next edge after RESET_N rises.
- FETCH: IR_LD=1, PC_INC=1. Goes to EXEC. One cycle.
- EXEC: EXEC_EN=1.
  - If INT_PEND=1 and I_FLAG=1, go to INTR; otherwise go to FETCH.
  - The decision uses the I_FLAG value registered before this cycle's I_SET/I_CLR update.
- INTR: INT_PC_LD=1, PC_MUX_SEL=2'b10, SP_DECR=1, SCR_WE=1, SCR_ADDR_SEL=2'b11, SCR_DATA_SEL=1, FLG_SHAD_LD=1.
  - On exit: I_FLAG<=0, INT_PEND<=0, go to FETCH. One cycle.
- I_FLAG update:
  - Honoured only in EXEC. I_SET or I_CLR in any other state is ignored.
  - I_CLR has priority over I_SET when both are high.
  - Entry to INTR clears I_FLAG, overriding everything.
- Interrupt capture:
  - INT passes through SYNC_STAGES flops, then one edge-detect flop.
  - A rise on the synchronized signal sets INT_PEND on the following edge. For INT rising before edge k, INT_PEND is high after edge k+SYNC_STAGES.
  - INT_PEND is sticky. It is cleared only on leaving INTR or by reset.
  - A new edge detected in the same cycle as the INTR clear wins: INT_PEND stays 1.
  - Pending is held indefinitely while I_FLAG=0 and is serviced at the first EXEC with I_FLAG=1.
  - Level-high INT generates no further requests.
- Instruction throughput: 2 cycles per instruction; interrupt entry adds 1 cycle.
- Reset mid-INTR or mid-EXEC: immediate INIT. No partial push completes after reset assertion.
- Unreachable STATE encoding: none exists (2 bits, 4 states). The default branch still goes to INIT.

Decomposition:
- Package mcu_pkg holds:
  - state_t enum (INIT, FETCH, EXEC, INTR);
  - PC_MUX_FROM_IR=2'b00 and PC_MUX_VECTOR=2'b10;
  - SCR_ADDR_SP_M1=2'b11.
- Sub-module int_sync: parameterized synchronizer plus rising-edge detector, output a single-cycle pulse. The pending latch stays in mcu_sequencer.

Test Plan:
- Reset release: RESET_N 0→1 → STATE 00 one cycle (MCU_RST=1), then repeats 01,10,01,10. IR_LD/PC_INC high in 01, EXEC_EN high in 10.
- Interrupt disabled: I_FLAG=0, pulse INT for 3 cycles → INT_PEND=1 after 2 edges, no INTR, STATE keeps alternating 01/10. Then I_SET in EXEC → next EXEC goes to INTR.
- Interrupt entry: I_FLAG=1, INT rises → INTR within ≤2 instruction cycles, with INT_PC_LD=1, PC_MUX_SEL=10, SCR_WE=1, SP_DECR=1, FLG_SHAD_LD=1 for exactly 1 cycle. Afterwards I_FLAG=0, INT_PEND=0.
- Priority: I_SET=I_CLR=1 in EXEC → I_FLAG=0. I_SET asserted during FETCH → I_FLAG unchanged.
- Re-trigger: second INT edge arriving in the INTR cycle → INT_PEND remains 1 after INTR exit. After RETIE (I_SET) in the next EXEC, the following EXEC enters INTR again.
- Async reset in INTR: drop RESET_N mid-cycle → all outputs immediately reset values, MCU_RST=1, I_FLAG=0, INT_PEND=0. No SCR_WE observed after assertion.
